ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
Burst initiator that drives the single-port synchronous RAM port (cs / rw / addr / data_in / data_out, 1-cycle read latency, rw=1 read, rw=0 write). It accepts one burst command (start address, beat count, direction) and streams write beats into the RAM or read beats out of it. Streaming uses valid/ready handshakes, and reads have full-throughput backpressure. It sits between the microcontroller datapath and the RAM instance and is the only master on that port.

Parameters:
AW, 8, RAM address width; also the width of the burst length field.
DW, 11, RAM data width.

Ports:
clk  in  1  global clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  burst command valid.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_rw  in  1  1 = read burst, 0 = write burst.
cmd_addr  in  AW  start address.
cmd_len  in  AW  beats minus 1 (0 means 1 beat, 2^AW-1 means 2^AW beats).
wr_data  in  DW  write beat data.
wr_valid  in  1  write beat valid.
wr_ready  out  1  write beat accepted when wr_valid & wr_ready.
rd_data  out  DW  read beat data.
rd_valid  out  1  read beat valid.
rd_ready  in  1  read beat consumed when rd_valid & rd_ready.
busy  out  1  high whenever the FSM is not in IDLE.
done  out  1  one-cycle pulse at burst completion.
mem_cs  out  1  RAM chip select.
mem_rw  out  1  RAM direction (1 read, 0 write).
mem_addr  out  AW  RAM address.
mem_wdata  out  DW  RAM write data.
mem_rdata  in  DW  RAM data_out.

Behaviour:
- Reset (async, immediate): state IDLE, addr/count regs 0, read FIFO empty, in-flight flag 0.
  - Outputs under reset: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, mem_cs=0, mem_rw=1, mem_addr=0, mem_wdata=0.
- State IDLE
  - cmd_ready=1.
  - On accept: latch addr<=cmd_addr and cnt<=cmd_len; go to WR (cmd_rw=0) or RD (cmd_rw=1).
- State WR
  - wr_ready=1 (combinational from state).
  - mem_cs = wr_valid; mem_rw=0; mem_addr=addr; mem_wdata=wr_data (combinational). One beat per handshake cycle.
  - Each accepted beat: addr<=addr+1 mod 2^AW.
  - If cnt==0, assert done next cycle and return to IDLE; else cnt<=cnt-1.
  - wr_valid low: no RAM access, no state change.
- State RD
  - Issue rule: issue = (remaining beats > 0) & (occ + inflight - pop < 2).
    - occ = 2-entry read FIFO occupancy; inflight = read issued last cycle; pop = rd_valid & rd_ready.
  - On issue: mem_cs=1, mem_rw=1, mem_addr=addr; addr increments with wrap.
  - Data capture: mem_rdata is written into the FIFO in the cycle after the issue (inflight=1). The FIFO never overflows.
  - rd_valid = occ>0 and rd_data = FIFO head, both registered from FIFO storage. Push and pop in the same cycle are allowed.
  - Latency: with rd_ready=1 held, first rd_valid comes 2 cycles after command accept. Beats then flow 1 per cycle; N beats in N+1 cycles after the first issue.
  - After the last issue, go to DRAIN.
- State DRAIN
  - No issues.
  - When inflight=0, occ=1 and pop occurs (or occ reaches 0), pulse done next cycle and return to IDLE.
- mem_rw=1 whenever the controller is not writing. mem_cs=0 outside WR/RD issue cycles.
- done: exactly one cycle per burst, with busy still 1 during that cycle. The next command is accepted from the following cycle.
- Address wrap: addr 2^AW-1 is followed by 0, with no error.
- Reset mid-burst drops mem_cs combinationally, flushes the FIFO and discards pending beats. RAM contents already written are kept.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- Write burst: AW=8, DW=11, cmd_rw=0, addr=0x10, len=3, data 0x001,0x0A5,0x7FF,0x123 with wr_valid always high -> 4 consecutive cycles mem_cs=1/mem_rw=0 at addrs 0x10..0x13; done 1 cycle later. Then a read burst from the same addr/len returns the same 4 values in order, done after the 4th pop.
- Read backpressure: read burst len=7, rd_ready toggling 1,0,0,1,... -> all 8 beats delivered in order, none dropped or duplicated, and mem_cs never issues with occ+inflight-pop=2.
- Wrap: write then read with addr=0xFE, len=3 -> RAM accesses 0xFE,0xFF,0x00,0x01, data correct.
- Single beat: len=0 read of a preloaded value 0x055 -> rd_valid 2 cycles after accept, rd_data=0x055, done pulse once, busy falls.
- Reset mid-burst: assert rst during beat 2 of a len=5 write -> mem_cs=0 same cycle, all outputs at reset values. A new command after release works, and addrs 0..1 of the old burst hold the written data.
- Throughput: read len=15 with rd_ready=1 -> 16 beats in 17 cycles from first issue, done after the last pop.

Source files
------------

// File: rtl/ram_burst_ctrl_if.sv
// Signal bundle between the burst controller, its command/stream user and the RAM port.
// The master modport is the controller's view; slave is the user/RAM side.
interface ram_burst_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 11
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          busy;
    logic          done;
    logic          mem_cs;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    dbg_state;

    // Every stream moves one item in a cycle where its valid and ready are both high;
    // valid never waits on ready, and ready may depend only on state.
    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        output mem_cs, mem_rw, mem_addr, mem_wdata, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        input  mem_cs, mem_rw, mem_addr, mem_wdata, dbg_state
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM (1-cycle read latency).
// Streams write beats into the RAM, or read beats out through a 2-entry skid FIFO.
module ram_burst_ctrl #(
    parameter int AW = 8,
    parameter int DW = 11
) (
    input  logic             clk,
    input  logic             rst,
    ram_burst_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    occ_q, occ_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] fifo_q [2];

    logic          pop;
    logic          push;
    logic          issue;
    logic          wr_beat;
    logic [2:0]    level;

    assign pop   = (occ_q != 2'd0) && bus.rd_ready;
    assign push  = inflight_q;
    // Entries that will be held once this cycle's pop retires; a new read may
    // only go out if its data is guaranteed a free slot when it returns.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wr_beat = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    cnt_d   = bus.cmd_len;
                    state_d = bus.cmd_rw ? S_RD : S_WR;
                end
            end
            S_WR: begin
                if (bus.wr_valid) begin
                    wr_beat = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - AW'(1);
                end
            end
            S_RD: begin
                if (level < 3'd2) begin
                    issue  = 1'b1;
                    addr_d = addr_q + AW'(1);
                    if (cnt_q == '0) state_d = S_DRAIN;
                    else             cnt_d   = cnt_q - AW'(1);
                end
            end
            S_DRAIN: begin
                if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign inflight_d = issue;
    assign occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    assign rd_ptr_d   = rd_ptr_q ^ pop;
    assign wr_ptr_d   = wr_ptr_q ^ push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) fifo_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.wr_ready  = (state_q == S_WR);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rd_valid  = (occ_q != 2'd0);
    assign bus.rd_data   = fifo_q[rd_ptr_q];
    assign bus.mem_cs    = wr_beat | issue;
    assign bus.mem_rw    = (state_q != S_WR);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = (state_q == S_WR) ? bus.wr_data : '0;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 1-cycle-latency RAM.
module tb_ram_burst_ctrl;
    localparam int AW = 8;
    localparam int DW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_burst_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Behavioural RAM on the controller's memory port
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (!bus.mem_rw) ram[bus.mem_addr] <= bus.mem_wdata;
            else             ram_rdata <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] wbuf   [0:15];
    logic [DW-1:0] shadow [0:255];
    logic [DW-1:0] exp_q  [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_cs, bus.mem_rw} !== 7'b1000001) begin
            n_err++;
            $display("FAIL %s_ctrl got=%b exp=1000001", tag,
                     {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_cs, bus.mem_rw});
        end
        n_cmp++;
        if ({bus.rd_data, bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL %s_data got rd_data=%h mem_addr=%h mem_wdata=%h exp all 0", tag,
                     bus.rd_data, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [7:0] a, input logic [7:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_ready got=%b exp=1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] len, input logic gap);
        send_cmd(1'b0, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap && i == 1) begin
                bus.wr_valid  = 1'b0;
                bus.cmd_valid = 1'b1;
                #1;
                n_cmp++;
                if ({bus.mem_cs, bus.cmd_ready, bus.busy} !== 3'b001) begin
                    n_err++;
                    $display("FAIL wr_gap got cs/cmd_ready/busy=%b exp=001",
                             {bus.mem_cs, bus.cmd_ready, bus.busy});
                end
                tick();
                bus.cmd_valid = 1'b0;
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wbuf[i];
            #1;
            n_cmp++;
            if ({bus.mem_cs, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.wr_ready, bus.cmd_ready} !==
                {1'b1, 1'b0, 8'(int'(a) + i), wbuf[i], 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL wr_beat%0d got cs=%b rw=%b addr=%h wdata=%h wr_ready=%b cmd_ready=%b exp cs=1 rw=0 addr=%h wdata=%h 1 0",
                         i, bus.mem_cs, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.wr_ready, bus.cmd_ready,
                         8'(int'(a) + i), wbuf[i]);
            end
            shadow[8'(int'(a) + i)] = wbuf[i];
            tick();
        end
        bus.wr_valid = 1'b0;
        #1;
        n_cmp++;
        if ({bus.done, bus.busy, bus.mem_cs} !== 3'b110) begin
            n_err++;
            $display("FAIL wr_done got done/busy/cs=%b exp=110", {bus.done, bus.busy, bus.mem_cs});
        end
        tick();
        n_cmp++;
        if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL wr_idle got done/busy/cmd_ready=%b exp=001", {bus.done, bus.busy, bus.cmd_ready});
        end
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0 repeating
    task automatic do_read(input logic [7:0] a, input logic [7:0] len, input int mode);
        int t0, issues, pops, first_issue, first_valid, last_pop;
        logic seen_done, pop;
        logic [DW-1:0] e;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(shadow[8'(int'(a) + i)]);
        send_cmd(1'b1, a, len);
        t0 = cyc; issues = 0; pops = 0; first_issue = -1; first_valid = -1; last_pop = -1;
        seen_done = 1'b0;
        for (int k = 0; k < 300 && !seen_done; k++) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            #1;
            pop = bus.rd_valid && bus.rd_ready;
            if (bus.rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (bus.mem_cs === 1'b1) begin
                n_cmp++;
                if ({bus.mem_rw, bus.mem_addr} !== {1'b1, 8'(int'(a) + issues)} ||
                    (issues - pops - int'(pop)) >= 2 || issues > int'(len)) begin
                    n_err++;
                    $display("FAIL rd_issue%0d got rw=%b addr=%h outstanding=%0d exp rw=1 addr=%h outstanding<2",
                             issues, bus.mem_rw, bus.mem_addr, issues - pops - int'(pop), 8'(int'(a) + issues));
                end
                if (first_issue < 0) first_issue = cyc;
                issues++;
            end
            if (pop) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_extra got beat=%h exp none", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd_data !== e) begin
                        n_err++;
                        $display("FAIL rd_beat%0d got=%h exp=%h", pops, bus.rd_data, e);
                    end
                end
                pops++;
                last_pop = cyc;
            end
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                n_cmp++;
                if (exp_q.size() != 0 || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rd_done got left=%0d busy=%b exp left=0 busy=1", exp_q.size(), bus.busy);
                end
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        #1;
        n_cmp++;
        if (!seen_done) begin
            n_err++;
            $display("FAIL rd_timeout got no done exp done");
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL rd_idle got done/busy/cmd_ready=%b exp=001", {bus.done, bus.busy, bus.cmd_ready});
        end
        n_cmp++;
        if (issues != int'(len) + 1 || pops != int'(len) + 1) begin
            n_err++;
            $display("FAIL rd_count got issues=%0d pops=%0d exp=%0d", issues, pops, int'(len) + 1);
        end
        if (mode == 0) begin
            n_cmp++;
            if (first_valid - t0 != 2) begin
                n_err++;
                $display("FAIL rd_latency got=%0d exp=2", first_valid - t0);
            end
            n_cmp++;
            if (last_pop - first_issue != int'(len) + 2) begin
                n_err++;
                $display("FAIL rd_throughput got=%0d exp=%0d", last_pop - first_issue, int'(len) + 2);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wbuf[0] = 11'h001; wbuf[1] = 11'h0A5; wbuf[2] = 11'h7FF; wbuf[3] = 11'h123;
        do_write(8'h10, 8'd3, 1'b0);
        do_read(8'h10, 8'd3, 0);
    endtask

    task automatic test_wrap();
        wbuf[0] = 11'h2AA; wbuf[1] = 11'h155; wbuf[2] = 11'h0F0; wbuf[3] = 11'h70F;
        do_write(8'hFE, 8'd3, 1'b1);
        do_read(8'hFE, 8'd3, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 11'(i * 37 + 5);
        do_write(8'h80, 8'd7, 1'b0);
        do_read(8'h80, 8'd7, 1);
    endtask

    task automatic test_single_beat();
        wbuf[0] = 11'h055;
        do_write(8'h40, 8'd0, 1'b0);
        do_read(8'h40, 8'd0, 0);
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 16; i++) wbuf[i] = 11'(2047 - i * 13);
        do_write(8'hA0, 8'd15, 1'b0);
        do_read(8'hA0, 8'd15, 0);
    endtask

    task automatic test_reset_mid();
        wbuf[0] = 11'h011; wbuf[1] = 11'h022; wbuf[2] = 11'h033;
        do_write(8'h00, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) wbuf[i] = 11'(11'h400 + i);
        send_cmd(1'b0, 8'h00, 8'd5);
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wbuf[i];
            shadow[i]    = wbuf[i];
            tick();
        end
        bus.wr_data = wbuf[2];
        #1;
        n_cmp++;
        if (bus.mem_cs !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre got cs=%b exp=1", bus.mem_cs);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        bus.wr_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_read(8'h00, 8'd2, 0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_single_beat();
        test_throughput();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
